dpram_port_arb: RTL and testbench

Round-robin arbiter and clear sequencer that shares one synchronous port of a dual-port RAM between up to NREQ requesters. Each requester issues single-word reads or writes over a req/gnt handshake and receives read data a fixed two cycles after grant. A built-in clear engine fills the whole RAM with a constant, on request or after reset, blocking requesters while it runs. It sits between CPU/DMA/video-fetch clients and the shared RAM port in the core's memory subsystem.

---
 rtl/dpram_arb_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/dpram_port_arb.sv | 117 +++++++++++
 tb/tb_dpram_port_arb.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_arb_pkg.sv
// Shared types and the round-robin winner search used by the RAM port arbiter.
package dpram_arb_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } arb_state_e;

  localparam int MAX_REQ = 8;

  // Returns {found, index}: first requester at or after ptr, wrapping modulo nreq.
  function automatic logic [3:0] rr_search(input logic [MAX_REQ-1:0] req,
                                           input logic [2:0] ptr,
                                           input int nreq);
    logic [3:0] res;
    int cand;
    res = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < nreq) begin
        cand = (int'(ptr) + k) % nreq;
        if (req[cand[2:0]]) res = {1'b1, cand[2:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, rotating priority pointer held inside.
module rr_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] ptr;
  logic [3:0]    pick;

  always_comb begin
    pick = rr_search(MAX_REQ'(req), 3'(ptr), NREQ);
    any  = en & pick[3];
    idx  = IW'(pick[2:0]);
    gnt  = any ? (NREQ'(1) << idx) : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (any) begin
      ptr <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/dpram_port_arb.sv
// Shares one synchronous RAM port between NREQ requesters and runs a whole-RAM clear.
//   state | meaning
//   RUN   | requesters arbitrated round-robin, one access per cycle
//   CLEAR | counter sweeps every address writing CLEAR_VALUE, requesters blocked
module dpram_port_arb
  import dpram_arb_pkg::*;
#(
  parameter int             NREQ           = 3,
  parameter int             AW             = 8,
  parameter int             DW             = 8,
  parameter logic [DW-1:0]  CLEAR_VALUE    = '0,
  parameter bit             CLEAR_ON_RESET = 1'b1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  input  logic               clear_start,
  output logic               clear_busy,
  output logic               clear_done,
  output logic [AW-1:0]      mem_address,
  output logic [DW-1:0]      mem_data,
  output logic               mem_wren,
  output logic               mem_byteena,
  input  logic [DW-1:0]      mem_q
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e    state;
  logic [AW-1:0] clr_cnt;
  logic          arb_en;
  logic          win_any;
  logic [IW-1:0] win_idx;
  logic          we_sel;
  logic [AW-1:0] addr_sel;
  logic [DW-1:0] wdata_sel;
  logic          tag_v1, tag_v2;
  logic [IW-1:0] tag_i1, tag_i2;

  // A clear request steals its own cycle so the sweep starts on a clean port.
  assign arb_en = reset_n && (state == RUN) && !clear_start;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req),
    .en      (arb_en),
    .gnt     (gnt),
    .idx     (win_idx),
    .any     (win_any)
  );

  assign we_sel      = we[win_idx];
  assign addr_sel    = addr[win_idx*AW +: AW];
  assign wdata_sel   = wdata[win_idx*DW +: DW];
  assign rvalid      = tag_v2 ? (NREQ'(1) << tag_i2) : '0;
  assign rdata       = mem_q;
  assign mem_byteena = 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= CLEAR_ON_RESET ? CLEAR : RUN;
      clear_busy  <= CLEAR_ON_RESET;
      clear_done  <= 1'b0;
      clr_cnt     <= '0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_wren    <= 1'b0;
      tag_v1      <= 1'b0;
      tag_v2      <= 1'b0;
      tag_i1      <= '0;
      tag_i2      <= '0;
    end else begin
      clear_done <= 1'b0;
      // Read tags run independently of state so reads granted before a clear still complete.
      tag_v1     <= win_any && !we_sel;
      tag_i1     <= win_idx;
      tag_v2     <= tag_v1;
      tag_i2     <= tag_i1;
      case (state)
        RUN: begin
          if (clear_start) begin
            state      <= CLEAR;
            clear_busy <= 1'b1;
            clr_cnt    <= '0;
            mem_wren   <= 1'b0;
          end else if (win_any) begin
            mem_address <= addr_sel;
            mem_data    <= wdata_sel;
            mem_wren    <= we_sel;
          end else begin
            mem_wren <= 1'b0;
          end
        end
        CLEAR: begin
          mem_address <= clr_cnt;
          mem_data    <= CLEAR_VALUE;
          mem_wren    <= 1'b1;
          clr_cnt     <= clr_cnt + 1'b1;
          if (clr_cnt == '1) begin
            state      <= RUN;
            clear_busy <= 1'b0;
            clear_done <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_port_arb.sv
// Bench for dpram_port_arb: cycle-level reference model checked every cycle plus directed literal checks.
module tb_dpram_port_arb;

  localparam int            NREQ  = 3;
  localparam int            AW    = 5;
  localparam int            DW    = 8;
  localparam int            DEPTH = 1 << AW;
  localparam logic [DW-1:0] CV    = 8'h00;

  logic               clock;
  logic               reset_n;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic               clear_start;
  logic               clear_busy;
  logic               clear_done;
  logic [AW-1:0]      mem_address;
  logic [DW-1:0]      mem_data;
  logic               mem_wren;
  logic               mem_byteena;
  logic [DW-1:0]      mem_q;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  dpram_port_arb #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .CLEAR_VALUE(CV), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .clear_start(clear_start),
    .clear_busy(clear_busy), .clear_done(clear_done), .mem_address(mem_address),
    .mem_data(mem_data), .mem_wren(mem_wren), .mem_byteena(mem_byteena), .mem_q(mem_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous RAM behind the port, registered read.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clock) begin
    if (mem_wren) ram[mem_address] <= mem_data;
    mem_q <= ram[mem_address];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: RAM contents as seen in grant order, and read results due two cycles on.
  typedef struct {int due; int idx; logic [DW-1:0] data;} rd_t;
  rd_t           pq[$];
  logic [DW-1:0] m_ram [DEPTH];
  int            m_ptr, m_clr;
  bit            m_done;
  logic          m_wren;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]   = 8'(i * 7 + 1);
      m_ram[i] = 8'(i * 7 + 1);
    end
    mem_q = '0;
  end

  always @(negedge clock) begin : model
    int gi;
    int a;
    logic [NREQ-1:0] eg, erv;
    logic [DW-1:0]   ed;
    if (!reset_n) begin
      chk("rst_gnt", gnt, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_wren", mem_wren, 0);
      chk("rst_addr", mem_address, 0);
      chk("rst_data", mem_data, 0);
      chk("rst_busy", clear_busy, 1);
      chk("rst_done", clear_done, 0);
      m_ptr = 0; m_clr = 0; m_done = 0;
      m_wren = 0; m_addr = '0; m_data = '0;
      pq.delete();
    end else begin
      gi = -1;
      if (m_clr < 0 && !clear_start) begin
        for (int k = 0; k < NREQ; k++) begin
          if (gi < 0 && req[(m_ptr + k) % NREQ]) gi = (m_ptr + k) % NREQ;
        end
      end
      eg  = (gi >= 0) ? NREQ'(1 << gi) : '0;
      erv = '0;
      ed  = '0;
      if (pq.size() > 0 && pq[0].due == cyc) begin
        erv = NREQ'(1 << pq[0].idx);
        ed  = pq[0].data;
        void'(pq.pop_front());
      end
      chk("gnt", gnt, eg);
      chk("rvalid", rvalid, erv);
      if (erv != 0) chk("rdata", rdata, ed);
      chk("clear_busy", clear_busy, m_clr >= 0);
      chk("clear_done", clear_done, m_done);
      chk("mem_wren", mem_wren, m_wren);
      chk("mem_address", mem_address, m_addr);
      chk("mem_data", mem_data, m_data);
      chk("mem_byteena", mem_byteena, 1);

      m_done = 0;
      if (m_clr >= 0) begin
        m_ram[m_clr] = CV;
        m_wren = 1; m_addr = AW'(m_clr); m_data = CV;
        m_clr++;
        if (m_clr == DEPTH) begin
          m_clr  = -1;
          m_done = 1;
        end
      end else if (clear_start) begin
        m_clr  = 0;
        m_wren = 0;
      end else if (gi >= 0) begin
        a      = int'(addr[gi*AW +: AW]);
        m_wren = we[gi];
        m_addr = AW'(a);
        m_data = wdata[gi*DW +: DW];
        if (we[gi]) m_ram[a] = wdata[gi*DW +: DW];
        else pq.push_back('{cyc + 2, gi, m_ram[a]});
        m_ptr = (gi + 1) % NREQ;
      end else begin
        m_wren = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic access(input int r, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int gc);
    bit got;
    got = 0;
    gc  = -1;
    req[r] = 1'b1; we[r] = w; addr[r*AW +: AW] = a; wdata[r*DW +: DW] = d;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clock);
      if (gnt[r]) begin
        got = 1;
        gc  = cyc;
      end
      tick();
    end
    req[r] = 1'b0;
    if (!got) chk("grant_timeout", 0, 1);
  endtask

  task automatic wait_rv(input int r, output logic [DW-1:0] d, output int c);
    bit got;
    got = 0;
    d   = '0;
    c   = -1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clock);
      if (rvalid[r]) begin
        got = 1;
        d   = rdata;
        c   = cyc;
      end
    end
    if (!got) chk("rvalid_timeout", 0, 1);
  endtask

  task automatic count_clear(input string name);
    int  cnt, fa;
    bit  fin, seen;
    cnt = 0; fa = -1; fin = 0; seen = 0;
    for (int k = 0; k < 200 && !fin; k++) begin
      @(negedge clock);
      if (mem_wren && !seen) begin
        seen = 1;
        fa   = int'(mem_address);
      end
      if (clear_busy) cnt++;
      else fin = 1;
    end
    chk({name, "_busy_cycles"}, cnt, DEPTH);
    chk({name, "_first_addr"}, fa, 0);
    chk({name, "_done_pulse"}, clear_done, 1);
  endtask

  logic [2:0] exp_seq [6];

  initial begin
    int g0, g1, s, c;
    bit got, fin;
    logic [DW-1:0] d;
    exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    reset_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0; clear_start = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    count_clear("por");
    tick();

    // Write then read back through requester 1.
    access(1, 1'b1, 5'h10, 8'h5A, g0);
    access(1, 1'b0, 5'h10, 8'h00, g1);
    wait_rv(1, d, c);
    chk("raw_back_to_back", g1 - g0, 1);
    chk("rd_latency", c - g1, 2);
    chk("rd_5a", d, 8'h5A);
    tick();
    access(2, 1'b0, 5'h01, 8'h00, g0);

    // All three requesting continuously: strict rotation.
    addr = {5'd3, 5'd2, 5'd1};
    we   = '0;
    req  = 3'b111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      chk("rr_seq", gnt, exp_seq[k]);
      tick();
    end
    req = '0;
    repeat (3) tick();

    // Clear with requester 2 pending; a second clear_start mid-sweep must be ignored.
    clear_start = 1'b1;
    req[2] = 1'b1; we[2] = 1'b0; addr[2*AW +: AW] = 5'h10;
    s = cyc;
    @(negedge clock);
    chk("clr_start_nogrant", gnt, 0);
    tick();
    clear_start = 1'b0;
    got = 0; g0 = -1;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clock);
      if (gnt[2]) begin
        got = 1;
        g0  = cyc;
      end
      tick();
      clear_start = (k == 9) && !got;
    end
    clear_start = 1'b0;
    req[2] = 1'b0;
    chk("clr_wait", g0 - s, DEPTH + 1);
    wait_rv(2, d, c);
    chk("clr_read_value", d, CV);
    tick();

    // Read granted, clear requested next cycle: read still lands with old data.
    access(0, 1'b1, 5'h03, 8'h77, g0);
    access(0, 1'b0, 5'h03, 8'h00, g1);
    clear_start = 1'b1;
    @(negedge clock);
    tick();
    clear_start = 1'b0;
    @(negedge clock);
    chk("pre_clr_rvalid", rvalid, 3'b001);
    chk("pre_clr_rdata", rdata, 8'h77);
    fin = 0;
    for (int k = 0; k < 100 && !fin; k++) begin
      tick();
      @(negedge clock);
      if (!clear_busy) fin = 1;
    end
    chk("clr_finished", fin, 1);
    tick();

    // Reset in the middle of a sweep.
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clock);
      if (mem_wren && mem_address == 5'd7) got = 1;
      else tick();
    end
    chk("reached_addr7", got, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_wren", mem_wren, 0);
    chk("async_rst_addr", mem_address, 0);
    chk("async_rst_busy", clear_busy, 1);
    chk("async_rst_gnt", gnt, 0);
    tick();
    tick();
    reset_n = 1'b1;
    count_clear("restart");
    tick();

    // Sweep reads after clear.
    req[1] = 1'b1; we[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      addr[AW +: AW] = AW'(i * 4);
      tick();
    end
    req = '0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual running expected finished");
    $fatal(1);
  end

endmodule
